// File: rtl/fb_pkg.sv
// Shared frame-buffer package, used by the write-side and read-side address blocks.
//   FB_H_ACT / FB_V_ACT : stored frame geometry (pixels per line / lines per frame)
//   FB_ADDR_W           : frame-buffer address width
//   FB_DATA_W           : pixel width
//   fb_wr_state_t       : write-side sequencer states
package fb_pkg;

    localparam int unsigned FB_H_ACT  = 400;
    localparam int unsigned FB_V_ACT  = 300;
    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned FB_DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } fb_wr_state_t;

endpackage

// File: rtl/fb_write_addr_if.sv
// Pixel-stream in / frame-buffer write port out, bundled for fb_write_addr.
//   pix_valid, pix_sof, pix_eol, pix_data : raster pixel stream (no back-pressure)
//   we, waddr, wdata                      : frame-buffer write port
//   frame_done, frame_err                 : one-cycle frame status pulses
// Modports:
//   master : stream source / write-port sink (drives pixels, observes writes)
//   slave  : the address generator
interface fb_write_addr_if
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned DATA_W = FB_DATA_W
);

    logic              pix_valid;
    logic              pix_sof;
    logic              pix_eol;
    logic [DATA_W-1:0] pix_data;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              frame_done;
    logic              frame_err;

    modport master (
        output pix_valid, pix_sof, pix_eol, pix_data,
        input  we, waddr, wdata, frame_done, frame_err
    );

    modport slave (
        input  pix_valid, pix_sof, pix_eol, pix_data,
        output we, waddr, wdata, frame_done, frame_err
    );

endinterface

// File: rtl/fb_pos_ctr.sv
// Raster position tracker for the frame-buffer write side.
// Holds the input column/line counters and the running line base address, and
// qualifies each accepted pixel for storage. All *_c_o outputs are combinational
// and describe the pixel currently presented (after an optional restart).
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   step_i           : an accepted pixel is present this cycle
//   clear_i          : restart at (0,0) with base 0 before handling this pixel
//   eol_i            : accepted pixel is the last of its line
//   store_en_c_o     : pixel lands inside the stored frame
//   x_st_c_o         : stored column of the pixel (zero-extended)
//   base_c_o         : linear address of the start of the current stored line
//   last_line_c_o    : pixel belongs to the last input line of the frame
//   short_line_c_o   : column is before the last expected input column
// Configuration macro: FB_WR_DECIM_EN selects 2x decimation in both axes.
module fb_pos_ctr
    import fb_pkg::*;
#(
    parameter int unsigned H_ACT  = FB_H_ACT,
    parameter int unsigned V_ACT  = FB_V_ACT,
    parameter int unsigned ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_i,
    input  logic              clear_i,
    input  logic              eol_i,
    output logic              store_en_c_o,
    output logic [ADDR_W-1:0] x_st_c_o,
    output logic [ADDR_W-1:0] base_c_o,
    output logic              last_line_c_o,
    output logic              short_line_c_o
);

`ifdef FB_WR_DECIM_EN
    localparam int unsigned DECIM = 2;
`else
    localparam int unsigned DECIM = 1;
`endif

    // Input-domain extents; counters saturate one past the last useful position.
    localparam int unsigned X_SAT  = DECIM * H_ACT;
    localparam int unsigned Y_SAT  = DECIM * V_ACT;
    localparam int unsigned X_LAST = X_SAT - 1;
    localparam int unsigned Y_LAST = Y_SAT - 1;
    localparam int unsigned X_W    = $clog2(X_SAT + 1);
    localparam int unsigned Y_W    = $clog2(Y_SAT + 1);

    logic [X_W-1:0]    x_in_q, x_in_d;
    logic [Y_W-1:0]    y_in_q, y_in_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic [X_W-1:0]    x_cur;
    logic [Y_W-1:0]    y_cur;
    logic [ADDR_W-1:0] base_cur;
    logic [X_W-1:0]    x_st;
    logic [Y_W-1:0]    y_st;
    logic              keep;
    logic              line_adv;
    logic              y_ok;

    // Pixel qualification and next counter values.
    always_comb begin
        x_cur    = clear_i ? '0 : x_in_q;
        y_cur    = clear_i ? '0 : y_in_q;
        base_cur = clear_i ? '0 : base_q;

`ifdef FB_WR_DECIM_EN
        // Keep even columns of even lines; the base moves once per pair of lines.
        x_st     = x_cur >> 1;
        y_st     = y_cur >> 1;
        keep     = ~x_cur[0] & ~y_cur[0];
        line_adv = y_cur[0];
`else
        x_st     = x_cur;
        y_st     = y_cur;
        keep     = 1'b1;
        line_adv = 1'b1;
`endif

        y_ok           = (y_st < Y_W'(V_ACT));
        store_en_c_o   = keep & (x_st < X_W'(H_ACT)) & y_ok;
        x_st_c_o       = ADDR_W'(x_st);
        base_c_o       = base_cur;
        last_line_c_o  = (y_cur == Y_W'(Y_LAST));
        short_line_c_o = (x_cur < X_W'(X_LAST));

        x_in_d = x_in_q;
        y_in_d = y_in_q;
        base_d = base_q;

        if (step_i) begin
            if (eol_i) begin
                x_in_d = '0;
                y_in_d = (y_cur == Y_W'(Y_SAT)) ? y_cur : y_cur + Y_W'(1);
                base_d = (line_adv & y_ok) ? base_cur + ADDR_W'(H_ACT) : base_cur;
            end else begin
                x_in_d = (x_cur == X_W'(X_SAT)) ? x_cur : x_cur + X_W'(1);
                y_in_d = y_cur;
                base_d = base_cur;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_in_q <= '0;
            y_in_q <= '0;
            base_q <= '0;
        end else begin
            x_in_q <= x_in_d;
            y_in_q <= y_in_d;
            base_q <= base_d;
        end
    end

endmodule

// File: rtl/fb_write_addr.sv
// Frame-buffer write-side address generator.
// Tracks raster position of an incoming pixel stream and turns each stored pixel
// into a registered write (we/waddr/wdata) one cycle later. Addresses are
// row-major (y*H_ACT + x), built from a running line base, no multiplier.
// Ports:
//   clk  : pixel clock
//   rst  : asynchronous, active-high reset
//   bus  : fb_write_addr_if.slave (pixel stream in, write port and status out)
// Configuration macro: FB_WR_DECIM_EN selects 2x decimation in both axes.
module fb_write_addr
    import fb_pkg::*;
#(
    parameter int unsigned H_ACT  = FB_H_ACT,
    parameter int unsigned V_ACT  = FB_V_ACT,
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned DATA_W = FB_DATA_W
) (
    input logic           clk,
    input logic           rst,
    fb_write_addr_if.slave bus
);

    fb_wr_state_t      state_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              frame_done_q;
    logic              frame_err_q;

    logic              sof_c;
    logic              pix_acc_c;
    logic              store_en_c;
    logic              last_line_c;
    logic              short_line_c;
    logic [ADDR_W-1:0] x_st_c;
    logic [ADDR_W-1:0] base_c;
    logic [ADDR_W-1:0] waddr_c;

    // SOF is honoured in every state; other pixels only while a frame is open.
    assign sof_c     = bus.pix_valid & bus.pix_sof;
    assign pix_acc_c = bus.pix_valid & (bus.pix_sof | (state_q == ACTIVE));
    assign waddr_c   = base_c + x_st_c;

    fb_pos_ctr #(
        .H_ACT  (H_ACT),
        .V_ACT  (V_ACT),
        .ADDR_W (ADDR_W)
    ) u_pos (
        .clk            (clk),
        .rst            (rst),
        .step_i         (pix_acc_c),
        .clear_i        (sof_c),
        .eol_i          (bus.pix_eol),
        .store_en_c_o   (store_en_c),
        .x_st_c_o       (x_st_c),
        .base_c_o       (base_c),
        .last_line_c_o  (last_line_c),
        .short_line_c_o (short_line_c)
    );

    // Frame sequencer with registered write port and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (pix_acc_c) begin
                // waddr/wdata only move on a real write so they hold otherwise.
                if (store_en_c) begin
                    we_q    <= 1'b1;
                    waddr_q <= waddr_c;
                    wdata_q <= bus.pix_data;
                end

                // Abort of an open frame, or a line that ended early.
                frame_err_q <= (sof_c & (state_q == ACTIVE)) |
                               (bus.pix_eol & short_line_c);

                if (bus.pix_eol && last_line_c) begin
                    frame_done_q <= 1'b1;
                    state_q      <= DONE;
                end else begin
                    state_q      <= ACTIVE;
                end
            end
        end
    end

    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_fb_write_addr.sv
// Bench for fb_write_addr with a 4x3 stored frame (8x6 input when FB_WR_DECIM_EN).
// Reference model works on plain integer coordinates and computes addresses as
// y*H + x directly.
module tb_fb_write_addr;

    localparam int unsigned H  = 4;
    localparam int unsigned V  = 3;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 12;
`ifdef FB_WR_DECIM_EN
    localparam int unsigned DEC = 2;
`else
    localparam int unsigned DEC = 1;
`endif
    localparam int unsigned IN_W = H * DEC;
    localparam int unsigned IN_H = V * DEC;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fb_write_addr_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fb_write_addr #(
        .H_ACT  (H),
        .V_ACT  (V),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state.
    bit            m_active;
    int            m_x, m_y;
    logic          exp_we, exp_done, exp_err;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] obs_mem [0:H*V-1];

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_x      = 0;
        m_y      = 0;
        exp_we   = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    task automatic model_step(input bit v, input bit s, input bit e, input logic [DW-1:0] d);
        int xs, ys;
        bit keep;
        exp_we   = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (v && (s || m_active)) begin
            if (s) begin
                if (m_active) exp_err = 1'b1;
                m_x      = 0;
                m_y      = 0;
                m_active = 1'b1;
            end
            xs   = m_x / int'(DEC);
            ys   = m_y / int'(DEC);
            keep = (m_x % int'(DEC) == 0) && (m_y % int'(DEC) == 0);
            if (keep && xs < int'(H) && ys < int'(V)) begin
                exp_we   = 1'b1;
                exp_addr = AW'(ys * int'(H) + xs);
                exp_data = d;
            end
            if (e) begin
                if (m_x < int'(IN_W) - 1) exp_err = 1'b1;
                if (m_y == int'(IN_H) - 1) begin
                    exp_done = 1'b1;
                    m_active = 1'b0;
                end
                m_x = 0;
                m_y = m_y + 1;
            end else begin
                m_x = m_x + 1;
            end
        end
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ".we"},         32'(bus.we),         32'(exp_we));
        check({ph, ".waddr"},      32'(bus.waddr),      32'(exp_addr));
        check({ph, ".wdata"},      32'(bus.wdata),      32'(exp_data));
        check({ph, ".frame_done"}, 32'(bus.frame_done), 32'(exp_done));
        check({ph, ".frame_err"},  32'(bus.frame_err),  32'(exp_err));
    endtask

    // One pixel-clock cycle: drive, clock, model, sample 1 time unit later.
    task automatic px(input bit v, input bit s, input bit e, input logic [DW-1:0] d);
        bus.pix_valid = v;
        bus.pix_sof   = s;
        bus.pix_eol   = e;
        bus.pix_data  = d;
        @(posedge clk);
        model_step(v, s, e, d);
        #1;
        check_outputs("px");
        if (bus.we === 1'b1 && int'(bus.waddr) < int'(H * V))
            obs_mem[int'(bus.waddr)] = bus.wdata;
    endtask

    task automatic bubble();
        px(1'b0, 1'($urandom), 1'($urandom), DW'($urandom));
    endtask

    // One input line of n pixels with data y*IN_W+x and random bubbles.
    task automatic send_line(input int n, input int y, input bit sof_first);
        for (int x = 0; x < n; x++) begin
            if ($urandom_range(0, 3) == 0) bubble();
            px(1'b1, sof_first && (x == 0), x == n - 1, DW'(y * int'(IN_W) + x));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        for (int k = 0; k < int'(H * V); k++) obs_mem[k] = '1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_eol   = 1'b0;
        bus.pix_data  = '0;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // Pixels before any SOF are ignored.
        for (int i = 0; i < 6; i++) px(1'b1, 1'b0, 1'($urandom), DW'($urandom));

        // Clean full frame.
        for (int y = 0; y < int'(IN_H); y++) send_line(int'(IN_W), y, y == 0);
        check("full.done_pulse", 32'(bus.frame_done), 32'd1);
        check("full.last_waddr", 32'(bus.waddr), 32'd11);
        for (int k = 0; k < int'(H * V); k++)
            check($sformatf("full.mem%0d", k), 32'(obs_mem[k]),
                  32'((int'(DEC) * (k / int'(H))) * int'(IN_W) + int'(DEC) * (k % int'(H))));

        // Pixels after frame_done are ignored.
        for (int i = 0; i < 6; i++) px(1'b1, 1'b0, 1'($urandom), DW'($urandom));

        // Overlong first line, then the remaining lines.
        send_line(int'(IN_W + 2 * DEC), 0, 1'b1);
        check("long.no_err", 32'(bus.frame_err), 32'd0);
        for (int y = 1; y < int'(IN_H); y++) send_line(int'(IN_W), y, 1'b0);

        // Mid-frame SOF after five pixels.
        send_line(int'(IN_W), 0, 1'b1);
        px(1'b1, 1'b0, 1'b0, DW'(100));
        px(1'b1, 1'b1, 1'b0, DW'(12'h5a5));
        check("sof.err",   32'(bus.frame_err), 32'd1);
        check("sof.we",    32'(bus.we),        32'd1);
        check("sof.waddr", 32'(bus.waddr),     32'd0);
        check("sof.wdata", 32'(bus.wdata),     32'h5a5);
        for (int i = 0; i < int'(DEC); i++) px(1'b1, 1'b0, 1'b0, DW'(200 + i));
        check("sof.next_we",    32'(bus.we),    32'd1);
        check("sof.next_waddr", 32'(bus.waddr), 32'd1);

        // Short line: eol well before the last column.
        px(1'b1, 1'b0, 1'b1, DW'(300));
        check("short.err", 32'(bus.frame_err), 32'd1);
        for (int y = 1; y < int'(IN_H); y++) send_line(int'(IN_W), y, 1'b0);

        // SOF and EOL on the same pixel.
        px(1'b1, 1'b1, 1'b1, DW'(12'h123));
        check("soleol.waddr", 32'(bus.waddr), 32'd0);
        check("soleol.we",    32'(bus.we),    32'd1);
        for (int y = 1; y < int'(IN_H); y++) send_line(int'(IN_W), y, 1'b0);

        // Randomized stream.
        for (int i = 0; i < 600; i++) begin
            px($urandom_range(0, 3) != 0,
               $urandom_range(0, 59) == 0,
               $urandom_range(0, int'(IN_W)) == 0,
               DW'($urandom));
        end

        // Reset asserted during line 1.
        send_line(int'(IN_W), 0, 1'b1);
        px(1'b1, 1'b0, 1'b0, DW'(77));
        px(1'b1, 1'b0, 1'b0, DW'(78));
        #2;
        bus.pix_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) px(1'b1, 1'b0, 1'b0, DW'($urandom));
        px(1'b1, 1'b1, 1'b0, DW'(12'h0ab));
        check("rst.sof_waddr", 32'(bus.waddr), 32'd0);
        check("rst.sof_we",    32'(bus.we),    32'd1);
        px(1'b1, 1'b0, 1'b0, DW'(1));

        bus.pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
